// File: rtl/muldiv_iter_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carry it; flush and busy ride alongside.
`timescale 1ns/1ps
interface muldiv_iter_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: one result bit per cycle on operand magnitudes.
// Latency: XLEN+1 cycles accept-to-out_valid; 1 cycle for div-by-zero/overflow when FAST_SPEC.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts anywhere.
`timescale 1ns/1ps
module muldiv_iter #(
    parameter int XLEN      = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic          clk,
    input  logic          rstn,
    muldiv_iter_if.slave  io
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic       sign_q;   // product sign for multiplies, quotient sign for divides
        logic       sign_r;
        logic       spec;     // result already fixed at accept time
    } ctx_t;

    state_t          state;
    state_t          state_nxt;
    ctx_t            ctx;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] res_q;

    logic            accept;
    logic            in_div;
    logic            in_rem;
    logic            sa_use;
    logic            sb_use;
    logic            neg_a;
    logic            neg_b;
    logic            div_zero;
    logic            div_ovf;
    logic            in_spec;
    logic [XLEN-1:0] mag_a_in;
    logic [XLEN-1:0] mag_b_in;
    logic [XLEN-1:0] spec_val;

    always_comb begin
        in_div   = io.op[2];
        in_rem   = io.op[2] & io.op[1];
        sa_use   = (io.op == 3'd1) | (io.op == 3'd2) | (io.op == 3'd4) | (io.op == 3'd6);
        sb_use   = (io.op == 3'd1) | (io.op == 3'd4) | (io.op == 3'd6);
        neg_a    = sa_use & io.a[XLEN-1];
        neg_b    = sb_use & io.b[XLEN-1];
        mag_a_in = neg_a ? -io.a : io.a;
        mag_b_in = neg_b ? -io.b : io.b;
        div_zero = in_div & (io.b == '0);
        div_ovf  = in_div & ~io.op[0] & (io.a == MIN_VAL) & (io.b == '1);
        in_spec  = div_zero | div_ovf;
        if (div_zero) begin
            spec_val = in_rem ? io.a : '1;
        end else begin
            spec_val = in_rem ? '0 : MIN_VAL;
        end
    end

    assign accept = (state == IDLE) & io.in_valid & ~io.flush;

    // One iteration step: hi/lo hold the partial product or remainder/quotient pair.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [XLEN-1:0]   hi_nxt;
    logic [XLEN-1:0]   lo_nxt;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fin;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
        rem_sh  = {hi, lo[XLEN-1]};
        div_ge  = (rem_sh >= {1'b0, mag_b});
        // The true difference is below mag_b, so modulo-2^XLEN subtraction is exact.
        div_sub = rem_sh[XLEN-1:0] - mag_b;
        if (ctx.op[2]) begin
            hi_nxt = div_ge ? div_sub : rem_sh[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod   = {hi_nxt, lo_nxt};
        prod_s = ctx.sign_q ? -prod : prod;
        quo_s  = ctx.sign_q ? -lo_nxt : lo_nxt;
        rem_s  = ctx.sign_r ? -hi_nxt : hi_nxt;
        case (ctx.op)
            3'd0:       fin = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       fin = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: fin = quo_s;
            default:    fin = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (io.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nxt = (FAST_SPEC && in_spec) ? DONE : CALC;
                CALC: if (cnt == '0) state_nxt = DONE;
                DONE: if (io.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctx   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            mag_b <= '0;
            res_q <= '0;
        end else if (accept) begin
            ctx.op     <= io.op;
            ctx.sign_q <= neg_a ^ neg_b;
            ctx.sign_r <= neg_a;
            ctx.spec   <= in_spec;
            cnt        <= CW'(XLEN - 1);
            hi         <= '0;
            lo         <= mag_a_in;
            mag_b      <= mag_b_in;
            if (in_spec) begin
                res_q <= spec_val;
            end
        end else if ((state == CALC) && !io.flush) begin
            cnt <= cnt - CW'(1);
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            // Special-case results were loaded at accept and win over the iterated value.
            if ((cnt == '0) && !ctx.spec) begin
                res_q <= fin;
            end
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.busy      = (state != IDLE);
    assign io.result    = res_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench: a FAST_SPEC=1 and a FAST_SPEC=0 unit share every input so both paths
// are checked against the same hand-computed results.
`timescale 1ns/1ps
module tb_muldiv_iter;
    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_ready;

    int n_vec;
    int n_err;

    muldiv_iter_if #(.XLEN(32)) if0 ();
    muldiv_iter_if #(.XLEN(32)) if1 ();

    assign if0.flush     = flush;
    assign if0.in_valid  = in_valid;
    assign if0.op        = op;
    assign if0.a         = a;
    assign if0.b         = b;
    assign if0.out_ready = out_ready;
    assign if1.flush     = flush;
    assign if1.in_valid  = in_valid;
    assign if1.op        = op;
    assign if1.a         = a;
    assign if1.b         = b;
    assign if1.out_ready = out_ready;

    muldiv_iter #(.XLEN(32), .FAST_SPEC(1'b1)) dut_fast (.clk(clk), .rstn(rstn), .io(if0.slave));
    muldiv_iter #(.XLEN(32), .FAST_SPEC(1'b0)) dut_slow (.clk(clk), .rstn(rstn), .io(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op with out_ready high; report first result/cycle seen on each unit (0 = never).
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r0, output int l0,
                         output logic [31:0] r1, output int l1);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l0 = 0; l1 = 0; r0 = '0; r1 = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (l0 == 0 && if0.out_valid) begin l0 = c; r0 = if0.result; end
            if (l1 == 0 && if1.out_valid) begin l1 = c; r1 = if1.result; end
            if (l0 != 0 && l1 != 0) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_vec++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", if0.in_ready); end
        n_vec++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", if0.out_valid); end
        n_vec++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", if0.busy); end
        n_vec++; if (if0.result !== 32'h0) begin n_err++; $display("FAIL rst_result: got %h want 0", if0.result); end
    endtask

    // Table-driven: both units must give the same value after the full 33 cycles.
    task automatic run_table(input string name, input int n, input logic [2:0] ops[8],
                             input logic [31:0] xs[8], input logic [31:0] ys[8],
                             input logic [31:0] es[8], input int lat_fast);
        logic [31:0] r0, r1;
        int l0, l1;
        for (int i = 0; i < n; i++) begin
            do_op(ops[i], xs[i], ys[i], r0, l0, r1, l1);
            n_vec++; if (r0 !== es[i]) begin n_err++; $display("FAIL %s[%0d] fast result: got %h want %h", name, i, r0, es[i]); end
            n_vec++; if (r1 !== es[i]) begin n_err++; $display("FAIL %s[%0d] slow result: got %h want %h", name, i, r1, es[i]); end
            n_vec++; if (l0 != lat_fast) begin n_err++; $display("FAIL %s[%0d] fast latency: got %0d want %0d", name, i, l0, lat_fast); end
            n_vec++; if (l1 != 33) begin n_err++; $display("FAIL %s[%0d] slow latency: got %0d want 33", name, i, l1); end
        end
    endtask

    task automatic test_mul();
        logic [2:0]  ops[8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd1, 3'd0, 3'd3, 3'd0};
        logic [31:0] xs[8]  = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h12345678, 32'h0, 32'h0};
        logic [31:0] ys[8]  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h10, 32'h0, 32'h0};
        logic [31:0] es[8]  = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h23456780, 32'h0, 32'h0};
        run_table("mul", 6, ops, xs, ys, es, 33);
    endtask

    task automatic test_div();
        logic [2:0]  ops[8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] xs[8]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'h80000000, 32'h80000000};
        logic [31:0] ys[8]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] es[8]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'h0, 32'h80000000};
        run_table("div", 8, ops, xs, ys, es, 33);
    endtask

    task automatic test_spec();
        logic [2:0]  ops[8] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7, 3'd5, 3'd6};
        logic [31:0] xs[8]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd9, 32'hFFFFFFFB};
        logic [31:0] ys[8]  = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] es[8]  = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFFB};
        run_table("spec", 8, ops, xs, ys, es, 1);
    endtask

    task automatic test_hold();
        bit found;
        @(negedge clk);
        op = 3'd0; a = 32'd6; b = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 32'd1; b = 32'd1;
        found = 1'b0;
        for (int c = 1; c <= 40 && !found; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            found = if0.out_valid;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL hold_done: out_valid got 0 want 1 within 40 cycles"); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (if0.out_valid !== 1'b1 || if0.result !== 32'd42 || if0.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: got valid=%b result=%h in_ready=%b want 1/0000002a/0",
                         i, if0.out_valid, if0.result, if0.in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release valid: got %b want 0", if0.out_valid); end
        n_vec++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release in_ready: got %b want 1", if0.in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        bit seen;
        logic [31:0] r0, r1;
        int l0, l1;
        @(negedge clk);
        op = 3'd5; a = 32'd100; b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_vec++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL flush busy: got %b want 0", if0.busy); end
        n_vec++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL flush in_ready: got %b want 1", if0.in_ready); end
        n_vec++; if (if1.busy !== 1'b0) begin n_err++; $display("FAIL flush slow busy: got %b want 0", if1.busy); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (if0.out_valid || if1.out_valid) seen = 1'b1;
        end
        n_vec++; if (seen) begin n_err++; $display("FAIL flush no_result: out_valid got 1 want 0"); end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_vec++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL flush_wins busy: got %b want 0", if0.busy); end
        do_op(3'd5, 32'd100, 32'd7, r0, l0, r1, l1);
        n_vec++; if (r0 !== 32'd14) begin n_err++; $display("FAIL flush_next result: got %h want %h", r0, 32'd14); end
        n_vec++; if (l0 != 33) begin n_err++; $display("FAIL flush_next latency: got %0d want 33", l0); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] r0, r1;
        int l0, l1;
        @(negedge clk);
        op = 3'd3; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2; rstn = 1'b0; #1;
        n_vec++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid in_ready: got %b want 1", if0.in_ready); end
        n_vec++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL rstmid busy: got %b want 0", if0.busy); end
        n_vec++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid out_valid: got %b want 0", if0.out_valid); end
        n_vec++; if (if0.result !== 32'h0) begin n_err++; $display("FAIL rstmid result: got %h want 0", if0.result); end
        @(negedge clk); rstn = 1'b1;
        do_op(3'd7, 32'd100, 32'd7, r0, l0, r1, l1);
        n_vec++; if (r0 !== 32'd2) begin n_err++; $display("FAIL rstmid_next result: got %h want %h", r0, 32'd2); end
        n_vec++; if (r1 !== 32'd2) begin n_err++; $display("FAIL rstmid_next slow result: got %h want %h", r1, 32'd2); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; op = 3'd0; a = '0; b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rstn = 1'b1;
        test_mul();
        test_div();
        test_spec();
        test_hold();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
